// File: rtl/common.sv
// common: pipeline-wide shared types and helpers.
package common;
  typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_t;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction
endpackage

// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: E-stage request/result bundle between the pipeline and the mult/div sequencer.
interface multdiv_ctrl_if;
  import common::*;
  logic        valid_i;
  mdu_op_t     op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        stall_i;
  logic        flush_i;
  logic        ok_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  modport master (output valid_i, op_i, a_i, b_i, stall_i, flush_i, input ok_o, done_o, hi_o, lo_o);
  modport slave (input valid_i, op_i, a_i, b_i, stall_i, flush_i, output ok_o, done_o, hi_o, lo_o);
endinterface

// File: rtl/div_iter.sv
// div_iter: restoring divider datapath, one unsigned quotient bit per step, MSB first.
module div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [32:0] shl, dif;
  // quo_o/rem_o are the values after the step in flight, so the last step's result is visible before it is registered
  assign shl = {rem_q, quo_q[31]};
  assign dif = shl - {1'b0, dvs_q};
  assign quo_o = {quo_q[30:0], ~dif[32]};
  assign rem_o = dif[32] ? shl[31:0] : dif[31:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      quo_q <= quo_o;
      rem_q <= rem_o;
    end
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: E-stage multiply/divide sequencer; stalls E via ok_o and holds HI/LO until the pipeline accepts them.
module multdiv_ctrl
  import common::*;
#(
  parameter int MULT_LAT = 3
) (
  input logic           clk,
  input logic           reset,
  multdiv_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(32);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t         state_q;
  logic [CNT_W-1:0] cnt_q;
  mdu_op_t        op_q;
  logic [31:0]    a_q, b_q, hi_q, lo_q, quo, rem, q_fix, r_fix;
  logic           done_q, sa_q, sb_q, start, is_div, sgn_div, mul_sgn;
  logic [63:0]    prod;
  assign start   = state_q == IDLE && bus.valid_i && !bus.flush_i;
  assign is_div  = bus.op_i == MDU_DIV || bus.op_i == MDU_DIVU;
  assign sgn_div = bus.op_i == MDU_DIV;
  assign mul_sgn = op_q == MDU_MULT;
  // sign-extending to 64 bits makes one unsigned multiply serve both MULT and MULTU
  assign prod  = {{32{mul_sgn && a_q[31]}}, a_q} * {{32{mul_sgn && b_q[31]}}, b_q};
  assign q_fix = (sa_q ^ sb_q) ? -quo : quo;
  assign r_fix = sa_q ? -rem : rem;
  assign bus.ok_o   = ~(start || state_q == MUL || state_q == DIV);
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .load_i    (start && is_div),
    .step_i    (state_q == DIV),
    .dividend_i(mag(bus.a_i, sgn_div)),
    .divisor_i (mag(bus.b_i, sgn_div)),
    .quo_o     (quo),
    .rem_o     (rem)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_MULT;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.flush_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.valid_i) begin
          op_q    <= bus.op_i;
          a_q     <= bus.a_i;
          b_q     <= bus.b_i;
          sa_q    <= sgn_div && bus.a_i[31];
          sb_q    <= sgn_div && bus.b_i[31];
          state_q <= is_div ? DIV : MUL;
          cnt_q   <= is_div ? CNT_W'(31) : CNT_W'(MULT_LAT - 1);
        end
        MUL: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            {hi_q, lo_q} <= prod;
            state_q      <= DONE;
            done_q       <= 1'b1;
          end
        end
        DIV: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            hi_q    <= (b_q == '0) ? a_q : r_fix;
            lo_q    <= (b_q == '0) ? 32'hFFFF_FFFF : q_fix;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: if (!bus.stall_i) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed checks of latency, results, stall, flush and reset behaviour.
module tb_multdiv_ctrl;
  import common::*;
  logic clk, reset;
  int   n_chk, n_fail;
  logic [31:0] exp_hi, exp_lo;
  multdiv_ctrl_if bus ();
  multdiv_ctrl #(.MULT_LAT(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // called at posedge+1 in a cycle where the block is idle; returns at posedge+2 of the DONE cycle
  task automatic run_op(input string tag, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] hi, input logic [31:0] lo);
    int n;
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    #1;
    n = 0;
    while (!bus.ok_o && n < 100) begin
      n++;
      @(posedge clk);
      #2;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
    chk({tag, "_hi"}, bus.hi_o, hi);
    chk({tag, "_lo"}, bus.lo_o, lo);
    exp_hi = hi;
    exp_lo = lo;
    bus.valid_i = 1'b0;
  endtask
  task automatic abort_div(input string tag, input int k);
    bus.valid_i = 1'b1;
    bus.op_i    = MDU_DIV;
    bus.a_i     = 32'd100;
    bus.b_i     = 32'd7;
    repeat (k) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    #1;
    chk({tag, "_ok"}, 32'(bus.ok_o), 32'd1);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_hi"}, bus.hi_o, exp_hi);
    chk({tag, "_lo"}, bus.lo_o, exp_lo);
    repeat (40) @(posedge clk);
    #2;
    chk({tag, "_late_done"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_late_hi"}, bus.hi_o, exp_hi);
    chk({tag, "_late_lo"}, bus.lo_o, exp_lo);
    @(posedge clk);
    #1;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.valid_i = 1'b0;
    bus.op_i    = MDU_MULT;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ok", 32'(bus.ok_o), 32'd1);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_hi", bus.hi_o, 32'd0);
    chk("rst_lo", bus.lo_o, 32'd0);
    bus.valid_i = 1'b1;
    #1;
    chk("rst_ok_valid", 32'(bus.ok_o), 32'd0);
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 4, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    @(posedge clk);
    #1;
    run_op("b2b_div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(posedge clk);
    #1;
    run_op("divu", MDU_DIVU, 32'd7, 32'd2, 33, 32'd1, 32'd3);
    @(posedge clk);
    #1;
    run_op("div0", MDU_DIV, 32'h0000_1234, 32'd0, 33, 32'h0000_1234, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    @(posedge clk);
    #1;
    run_op("div_negb", MDU_DIV, 32'd100, 32'hFFFF_FFF9, 33, 32'd2, 32'hFFFF_FFF2);
    @(posedge clk);
    #1;
    bus.stall_i = 1'b1;
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 4, 32'd1, 32'hFFFF_FFFE);
    bus.valid_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) bus.stall_i = 1'b0;
      #1;
      chk("stall_done", 32'(bus.done_o), 32'd1);
      chk("stall_ok", 32'(bus.ok_o), 32'd1);
      chk("stall_hi", bus.hi_o, exp_hi);
      chk("stall_lo", bus.lo_o, exp_lo);
    end
    bus.valid_i = 1'b0;
    @(posedge clk);
    #2;
    chk("stall_exit_done", 32'(bus.done_o), 32'd0);
    chk("stall_exit_ok", 32'(bus.ok_o), 32'd1);
    @(posedge clk);
    #1;
    abort_div("flush_it10", 10);
    abort_div("flush_last", 32);
    run_op("pre_rst", MDU_MULT, 32'd6, 32'd7, 4, 32'd0, 32'd42);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b1;
    bus.op_i    = MDU_MULT;
    bus.a_i     = 32'd9;
    bus.b_i     = 32'd9;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ok", 32'(bus.ok_o), 32'd0);
    chk("arst_done", 32'(bus.done_o), 32'd0);
    chk("arst_hi", bus.hi_o, 32'd0);
    chk("arst_lo", bus.lo_o, 32'd0);
    bus.valid_i = 1'b0;
    #1;
    chk("arst_ok_idle", 32'(bus.ok_o), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer for the E-stage multiply/divide resource. It accepts a MULT/MULTU/DIV/DIVU operation from the execute stage and runs a fixed-latency multiply or a 32-iteration restoring divide. It drives the `ok` signal that the hazard unit uses to stall E and to flush M. It also holds the HI/LO result until the pipeline accepts it.

## Interface
Parameters:
- `MULT_LAT`, default 3: cycles spent in MUL state. Legal values are ≥1.

Ports:
- `clk`  in  1: clock. This is the block's only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `valid_i`  in  1: E stage holds a mult/div instruction.
- `op_i`  in  `mdu_op_t` (2): operation; sampled when a start is taken.
- `a_i`  in  32: rs operand / dividend; sampled when a start is taken.
- `b_i`  in  32: rt operand / divisor; sampled when a start is taken.
- `stall_i`  in  1: E held for a reason other than this block (e.g. `~d_data_ok`).
- `flush_i`  in  1: abort the current operation (exception or redirect).
- `ok_o`  out  1: resource not blocking E. Feeds the hazard unit's `mult_ok`.
- `done_o`  out  1: `hi_o`/`lo_o` hold the result of the instruction currently in E.
- `hi_o`  out  32: HI result (product high word / remainder).
- `lo_o`  out  32: LO result (product low word / quotient).

## Operation
States: IDLE, MUL, DIV, DONE.

- **IDLE**
  - If `valid_i & ~flush_i`: latch `op_i`, `a_i`, `b_i` (start).
    - MULT/MULTU: go to MUL with `cnt = MULT_LAT-1`.
    - DIV/DIVU: go to DIV with `cnt = 31`.
  - Otherwise stay in IDLE.
- **MUL**
  - Product comes from the latched operands, signed or unsigned per op (64-bit).
  - Decrement `cnt` each cycle.
  - At `cnt==0`: register `{hi,lo} = product`; go to DONE.
- **DIV**
  - Magnitudes are taken at start (two's complement negate for DIV; raw operands for DIVU).
  - One restoring step per cycle, producing one quotient bit MSB-first.
  - At `cnt==0`: apply sign fix and register `lo = quotient`, `hi = remainder`; go to DONE.
  - Sign fix: quotient negated if `sa^sb`; remainder negated if `sa`.
  - Divide by zero (any variant): `hi = a_i`, `lo = 32'hFFFF_FFFF`, independent of the restoring path.
  - `-2^31 / -1` (DIV): `lo = 32'h8000_0000`, `hi = 0` (natural wrap).
- **DONE**
  - `done_o = 1`.
  - If `stall_i`: stay in DONE holding the result.
  - Else: go to IDLE. The instruction advances this cycle.
  - No restart is taken from DONE.
- **`ok_o` (combinational)**
  - `ok_o = ~((state==IDLE & valid_i & ~flush_i) | state==MUL | state==DIV)`.
  - Therefore `ok_o = 1` in DONE and in idle-without-request.
- **`flush_i` (any state)**
  - Next state is IDLE; no result is written.
  - `flush_i` has priority over start and over completion.
- **`hi_o`/`lo_o`**
  - Registered; updated only on the transition into DONE.
  - Hold their value otherwise, including across a flush.
- **`valid_i` deasserting while in MUL or DIV** (not legal without a flush): the operation completes normally.

## Timing
- **Reset values:** state IDLE, `cnt = 0`, `done_o = 0`, `hi_o = 0`, `lo_o = 0`. While in reset, `ok_o = ~valid_i`.
- **Start cycle:** `ok_o` is low in the same cycle `valid_i` rises (combinational path to stallE).
- **Multiply:** `ok_o` low for `1+MULT_LAT` cycles, then 1 cycle of DONE. With the default `MULT_LAT = 3`, start to DONE is 4 cycles.
- **Divide:** `ok_o` low for 33 cycles (start + 32 iterations), then DONE.
- **Back-to-back operations:**
  - Leaving DONE at edge n means the new instruction is in E from cycle n.
  - It sees IDLE and starts in cycle n with `ok_o` low.
  - Minimum gap is 0 bubbles beyond latency.
- **Late flush:** `flush_i` asserted in the last MUL/DIV cycle suppresses the DONE entry and the HI/LO write.
- **Reset mid-operation:** async return to IDLE; HI/LO cleared.

## Structure
- `mdu_op_t` goes in the shared `common` package: `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`.
- The state enum and the counter width (`$clog2(32)`) are local to the module.
- One sub-module, `div_iter`: the restoring divider datapath (remainder/quotient shift registers plus subtract-compare).
  - Its controls are `load`/`step` from this FSM.
  - Unsigned magnitudes in, unsigned quotient/remainder out.
- The multiplier is a `*` on the latched operands, with `MULT_LAT` for synthesis retiming.

## Test plan
- **MULT:** `a = -3`, `b = 5` -> `ok_o` low 4 cycles, then DONE with `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFF1`.
- **MULTU:** `a = 0xFFFFFFFF`, `b = 2` -> `hi = 0x00000001`, `lo = 0xFFFFFFFE`.
- **DIV and DIVU:**
  - DIV `-7/2` -> `ok_o` low 33 cycles, `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`.
  - DIVU `7/2` -> `lo = 3`, `hi = 1`.
  - DIV by zero with `a = 0x1234` -> `hi = 0x1234`, `lo = 0xFFFFFFFF`.
- **Flush mid-DIV:**
  - Pulse `flush_i` at iteration 10 -> IDLE next cycle, `ok_o = 1` with `valid_i` low, `hi_o`/`lo_o` unchanged from the prior result.
  - A second flush in the final DIV cycle -> no write.
- **Stall in DONE:** `stall_i` high for 3 cycles at DONE -> `done_o`/`ok_o` high for 4 cycles, no restart, HI/LO stable.
- **Back-to-back MULT then DIV:**
  - Second start in the cycle after DONE exit, with correct results.
  - Async `reset` during MUL -> all outputs at reset values immediately.
